// File: rtl/mnist_img_loader.sv
// mnist_img_loader
//   Upstream feeder for the MNIST inference core. It takes one 28x28 8-bit
//   image as a valid/ready byte stream and stores it in an on-chip image
//   buffer. It checks the frame length and sends the core a one-cycle start
//   pulse. It serves the core's pixel reads through a synchronous read port,
//   and it holds off the stream while the core is busy.
//
// Ports
//   clk        system clock, rising edge
//   rst        asynchronous reset, active low
//   s_valid    stream beat valid
//   s_data     pixel value
//   s_last     final beat of a frame
//   s_ready    loader accepts a beat (registered)
//   rd_addr    core pixel read address
//   rd_data    pixel at rd_addr, one-cycle latency; 0 for addresses >= NPIX
//   start      one-cycle pulse: a complete image is ready for the core
//   core_done  core done level; only its rising edge is used
//   img_valid  buffer holds a complete, accepted frame
//   frame_err  one-cycle pulse on a short or overlong frame
//   frame_cnt  number of start pulses issued, wraps mod 256
//
// Optional feature (macro LOADER_PINGPONG_EN)
//   The buffer becomes two banks. The next frame is loaded into the inactive
//   bank while the core works. A completed frame waits in S_PEND for the
//   core_done rise; the banks then swap. Reads always come from the active
//   bank. Without the macro there is a single bank and nothing is loaded
//   while the core is busy.
//
// States
//   state   | meaning
//   S_LOAD  | accepting pixels of a frame into the load bank
//   S_DROP  | overlong frame seen; discard beats up to and including s_last
//   S_START | one cycle: start pulse, mark image valid, count the frame
//   S_BUSY  | core running; wait for the core_done rise
//   S_PEND  | (ping-pong only) next frame loaded; wait for the core_done rise

module mnist_img_loader #(
  parameter int NPIX   = 784,
  parameter int PIX_W  = 8,
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              s_valid,
  input  logic [PIX_W-1:0]  s_data,
  input  logic              s_last,
  output logic              s_ready,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [PIX_W-1:0]  rd_data,
  output logic              start,
  input  logic              core_done,
  output logic              img_valid,
  output logic              frame_err,
  output logic [7:0]        frame_cnt
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NPIX - 1);

  typedef enum logic [2:0] {
    S_LOAD,
    S_DROP,
    S_START,
    S_BUSY,
    S_PEND
  } state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] wr_ptr, wr_ptr_nxt;
  logic [ADDR_W-1:0] ptr_step;
  logic              ready_nxt;
  logic              err_nxt;
  logic              clr_valid;
  logic              wr_en;
  logic              core_done_q;
  logic              done_rise;
  logic              accept;
  logic              at_end;
  logic              beat_full;
  logic              beat_short;
  logic              beat_long;

`ifdef LOADER_PINGPONG_EN
  logic              act_bank;
  logic              wr_bank;
  logic              swap;
  logic [PIX_W-1:0]  mem [2][NPIX];
`else
  logic [PIX_W-1:0]  mem [NPIX];
`endif

  assign accept     = s_valid && s_ready;
  assign at_end     = (wr_ptr == LAST_ADDR);
  assign beat_full  = s_last && at_end;
  assign beat_short = s_last && !at_end;
  assign beat_long  = !s_last && at_end;
  // Every frame-ending beat, good or bad, rewinds the pointer to pixel 0.
  assign ptr_step   = (s_last || at_end) ? '0 : wr_ptr + ADDR_W'(1);
  assign done_rise  = core_done && !core_done_q;
  assign start      = (state == S_START);

  always_comb begin
    state_nxt  = state;
    wr_ptr_nxt = wr_ptr;
    err_nxt    = 1'b0;
    clr_valid  = 1'b0;
    wr_en      = 1'b0;
`ifdef LOADER_PINGPONG_EN
    swap       = 1'b0;
`endif
    case (state)
      S_LOAD: begin
        if (accept) begin
          wr_en      = 1'b1;
          wr_ptr_nxt = ptr_step;
          clr_valid  = (wr_ptr == '0);
          err_nxt    = beat_short || beat_long;
          if (beat_full) begin
            state_nxt = S_START;
`ifdef LOADER_PINGPONG_EN
            swap      = 1'b1;
`endif
          end else if (beat_long) begin
            state_nxt = S_DROP;
          end
        end
      end
      S_DROP: begin
        if (accept && s_last) state_nxt = S_LOAD;
      end
      S_START: begin
        // A core_done rise seen in this cycle is intentionally dropped:
        // the core cannot have finished the image it is only now told about.
        state_nxt = S_BUSY;
      end
      S_BUSY: begin
`ifdef LOADER_PINGPONG_EN
        if (accept) begin
          wr_en      = 1'b1;
          wr_ptr_nxt = ptr_step;
          err_nxt    = beat_short || beat_long;
          if (beat_full) begin
            if (done_rise) begin
              state_nxt = S_START;
              swap      = 1'b1;
            end else begin
              state_nxt = S_PEND;
            end
          end else if (beat_long) begin
            state_nxt = S_DROP;
          end else if (done_rise) begin
            state_nxt = S_LOAD;
          end
        end else if (done_rise) begin
          // Core finished with no frame pending; a partial frame keeps its
          // progress and simply continues in S_LOAD.
          state_nxt = S_LOAD;
        end
`else
        if (done_rise) state_nxt = S_LOAD;
`endif
      end
`ifdef LOADER_PINGPONG_EN
      S_PEND: begin
        if (done_rise) begin
          state_nxt = S_START;
          swap      = 1'b1;
        end
      end
`endif
      default: state_nxt = S_LOAD;
    endcase
  end

  // s_ready is registered from the next state so it lines up with the state
  // register; out of reset it stays low until the first clock edge.
  always_comb begin
    ready_nxt = 1'b0;
    case (state_nxt)
      S_LOAD:  ready_nxt = 1'b1;
      S_DROP:  ready_nxt = 1'b1;
`ifdef LOADER_PINGPONG_EN
      S_BUSY:  ready_nxt = 1'b1;
`endif
      default: ready_nxt = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= S_LOAD;
      wr_ptr      <= '0;
      s_ready     <= 1'b0;
      img_valid   <= 1'b0;
      frame_err   <= 1'b0;
      frame_cnt   <= 8'd0;
      core_done_q <= 1'b0;
`ifdef LOADER_PINGPONG_EN
      act_bank    <= 1'b0;
`endif
    end else begin
      state       <= state_nxt;
      wr_ptr      <= wr_ptr_nxt;
      s_ready     <= ready_nxt;
      frame_err   <= err_nxt;
      core_done_q <= core_done;
      if (state == S_START) begin
        img_valid <= 1'b1;
        frame_cnt <= frame_cnt + 8'd1;
      end else if (clr_valid) begin
        img_valid <= 1'b0;
      end
`ifdef LOADER_PINGPONG_EN
      if (swap) act_bank <= ~act_bank;
`endif
    end
  end

`ifdef LOADER_PINGPONG_EN
  assign wr_bank = ~act_bank;

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_bank][wr_ptr] <= s_data;
  end

  // Non-blocking read of the array gives old data on a same-address write.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                       rd_data <= '0;
    else if (rd_addr <= LAST_ADDR)  rd_data <= mem[act_bank][rd_addr];
    else                            rd_data <= '0;
  end
`else
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= s_data;
  end

  // Non-blocking read of the array gives old data on a same-address write.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                       rd_data <= '0;
    else if (rd_addr <= LAST_ADDR)  rd_data <= mem[rd_addr];
    else                            rd_data <= '0;
  end
`endif

endmodule

// File: tb/tb_mnist_img_loader.sv
`timescale 1ns/1ps
// Testbench for mnist_img_loader. Builds with or without LOADER_PINGPONG_EN.

module tb_mnist_img_loader;

  localparam int NPIX   = 784;
  localparam int PIX_W  = 8;
  localparam int ADDR_W = 10;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              s_valid = 1'b0;
  logic [PIX_W-1:0]  s_data = '0;
  logic              s_last = 1'b0;
  logic              s_ready;
  logic [ADDR_W-1:0] rd_addr = '0;
  logic [PIX_W-1:0]  rd_data;
  logic              start;
  logic              core_done = 1'b0;
  logic              img_valid;
  logic              frame_err;
  logic [7:0]        frame_cnt;

  mnist_img_loader #(.NPIX(NPIX), .PIX_W(PIX_W), .ADDR_W(ADDR_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .s_valid   (s_valid),
    .s_data    (s_data),
    .s_last    (s_last),
    .s_ready   (s_ready),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .start     (start),
    .core_done (core_done),
    .img_valid (img_valid),
    .frame_err (frame_err),
    .frame_cnt (frame_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // scoreboard queues
  int               exp_start_cyc_q[$];
  int               exp_start_cnt_q[$];
  int               exp_err_q[$];
  logic [PIX_W-1:0] rd_exp_q[$];

  // reference model of the frame parser
  int m_wp   = 0;
  int m_cnt  = 0;
  bit m_drop = 1'b0;
  bit m_busy = 1'b0;
  bit m_pend = 1'b0;

  bit   cnt_chk    = 1'b0;
  int   cnt_exp    = 0;
  logic start_prev = 1'b0;
  logic err_prev   = 1'b0;

  task automatic chk_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] pix(input int seed, input int i);
    return 8'(i + seed * 37);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic model_beat(input logic last);
    if (m_drop) begin
      if (last) m_drop = 1'b0;
    end else if (last && m_wp == NPIX - 1) begin
      m_wp = 0;
      if (m_busy) begin
        m_pend = 1'b1;
      end else begin
        m_cnt = (m_cnt + 1) % 256;
        exp_start_cyc_q.push_back(cyc);
        exp_start_cnt_q.push_back(m_cnt);
        m_busy = 1'b1;
      end
    end else if (last) begin
      m_wp = 0;
      exp_err_q.push_back(cyc);
    end else if (m_wp == NPIX - 1) begin
      m_wp   = 0;
      m_drop = 1'b1;
      exp_err_q.push_back(cyc);
    end else begin
      m_wp++;
    end
  endtask

  task automatic send_beat(input logic [7:0] d, input logic last);
    int   guard = 0;
    logic acc;
    s_valid = 1'b1;
    s_data  = d;
    s_last  = last;
    while (!s_ready && guard < 2000) begin
      step();
      guard++;
    end
    acc = s_ready;
    if (!acc) chk_val("ready_timeout", s_ready, 1'b1);
    step();
    s_valid = 1'b0;
    s_last  = 1'b0;
    if (acc) model_beat(last);
  endtask

  task automatic send_frame(input int seed, input int n, input bit with_last);
    for (int i = 0; i < n; i++) begin
      if (i >= NPIX) chk_val("drop_ready", s_ready, 1'b1);
      send_beat(pix(seed, i), with_last && (i == n - 1));
    end
  endtask

  task automatic rd_chk(input logic [ADDR_W-1:0] a, input logic [7:0] e);
    rd_addr = a;
    rd_exp_q.push_back(e);
    step();
    chk_val("rd_data", rd_data, rd_exp_q.pop_front());
  endtask

  task automatic core_rise();
    core_done = 1'b0;
    step();
    core_done = 1'b1;
    if (m_pend) begin
      m_pend = 1'b0;
      m_cnt  = (m_cnt + 1) % 256;
      exp_start_cyc_q.push_back(cyc + 1);
      exp_start_cnt_q.push_back(m_cnt);
    end else begin
      m_busy = 1'b0;
    end
    step();
  endtask

  task automatic apply_reset();
    #2 rst = 1'b0;
    #1;
    chk_val("rst_s_ready",   s_ready,   1'b0);
    chk_val("rst_start",     start,     1'b0);
    chk_val("rst_img_valid", img_valid, 1'b0);
    chk_val("rst_frame_err", frame_err, 1'b0);
    chk_val("rst_frame_cnt", frame_cnt, 8'd0);
    chk_val("rst_rd_data",   rd_data,   8'd0);
    chk_val("start_q_left",  exp_start_cyc_q.size(), 0);
    chk_val("err_q_left",    exp_err_q.size(), 0);
    exp_start_cyc_q.delete();
    exp_start_cnt_q.delete();
    exp_err_q.delete();
    m_wp = 0; m_cnt = 0; m_drop = 1'b0; m_busy = 1'b0; m_pend = 1'b0;
    s_valid = 1'b0;
    s_last  = 1'b0;
    step();
    step();
    rst = 1'b1;
    chk_val("ready_at_release", s_ready, 1'b0);
    step();
    chk_val("ready_after_edge", s_ready, 1'b1);
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      cnt_chk    = 1'b0;
      start_prev = 1'b0;
      err_prev   = 1'b0;
    end else begin
      if (cnt_chk) begin
        chk_val("frame_cnt", frame_cnt, cnt_exp);
        chk_val("img_valid_set", img_valid, 1'b1);
        cnt_chk = 1'b0;
      end
      if (start) begin
        if (start_prev) begin
          chk_val("start_width", start_prev, 1'b0);
        end else if (exp_start_cyc_q.size() == 0) begin
          chk_val("start_unexp", start, 1'b0);
        end else begin
          chk_val("start_cyc", cyc, exp_start_cyc_q.pop_front());
          cnt_exp = exp_start_cnt_q.pop_front();
          cnt_chk = 1'b1;
        end
      end
      if (frame_err) begin
        if (err_prev) begin
          chk_val("err_width", err_prev, 1'b0);
        end else if (exp_err_q.size() == 0) begin
          chk_val("err_unexp", frame_err, 1'b0);
        end else begin
          chk_val("err_cyc", cyc, exp_err_q.pop_front());
        end
      end
      start_prev = start;
      err_prev   = frame_err;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog expired");
  end

  initial begin
    // reset, one good frame, reads incl. out-of-range
    apply_reset();
    send_frame(0, NPIX, 1'b1);
    rd_chk(10'd300, 8'h2C);
    rd_chk(10'd800, 8'h00);
    rd_chk(10'd1023, 8'h00);
    rd_chk(10'd0, pix(0, 0));
    rd_chk(10'd783, pix(0, 783));
`ifndef LOADER_PINGPONG_EN
    // stream held while the core is busy
    s_valid = 1'b1;
    s_data  = 8'hAA;
    s_last  = 1'b0;
    repeat (4) begin
      chk_val("busy_ready", s_ready, 1'b0);
      step();
    end
`endif
    core_rise();
    chk_val("ready_after_done", s_ready, 1'b1);
    s_valid = 1'b0;

    // short frame, then a good one
    send_frame(1, 100, 1'b1);
    chk_val("img_valid_short", img_valid, 1'b0);
    send_frame(2, NPIX, 1'b1);
`ifndef LOADER_PINGPONG_EN
    // core_done still high from before: no retrigger
    repeat (5) begin
      chk_val("held_done_ready", s_ready, 1'b0);
      step();
    end
`endif
    rd_chk(10'd5, pix(2, 5));
    core_rise();

    // overlong frame after reset, then a good one
    apply_reset();
    send_frame(8, 790, 1'b1);
    send_frame(3, NPIX, 1'b1);
    rd_chk(10'd7, pix(3, 7));
    core_rise();

    // reset in the middle of a frame
    rd_addr = 10'd7;
    send_frame(4, 400, 1'b0);
    apply_reset();
    send_frame(5, NPIX, 1'b1);
    rd_chk(10'd0, pix(5, 0));
    rd_chk(10'd399, pix(5, 399));
    rd_chk(10'd783, pix(5, 783));

`ifdef LOADER_PINGPONG_EN
    // load frame B while the core works on frame A
    send_frame(6, NPIX, 1'b1);
    chk_val("pend_ready", s_ready, 1'b0);
    rd_chk(10'd10, pix(5, 10));
    repeat (3) step();
    rd_chk(10'd20, pix(5, 20));
    core_rise();
    rd_chk(10'd10, pix(6, 10));
    rd_chk(10'd783, pix(6, 783));
    chk_val("img_valid_swap", img_valid, 1'b1);
`endif
    core_rise();
    chk_val("ready_final", s_ready, 1'b1);

    repeat (3) step();
    chk_val("start_q_end", exp_start_cyc_q.size(), 0);
    chk_val("err_q_end", exp_err_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mnist_img_loader.md
Name: mnist_img_loader

Overview:
Upstream feeder for the MNIST inference core (mnist_top_synth family).
- Receives a 784-pixel, 8-bit image as a valid/ready byte stream with end-of-frame marker and stores it in an on-chip image buffer.
- Checks frame length and issues a one-cycle start pulse to the core.
- Serves the core's pixel reads through a synchronous read port.
- Throttles the stream while the core is busy.

Parameters:
- NPIX, 784, pixels per frame (28x28).
- PIX_W, 8, pixel width in bits.
- ADDR_W, 10, buffer address width; must satisfy 2^ADDR_W >= NPIX.

Ports:
- clk  in  1  single system clock, rising-edge.
- rst  in  1  asynchronous, active-low reset.
- s_valid  in  1  stream beat valid.
- s_data  in  PIX_W  pixel value.
- s_last  in  1  marks final beat of frame.
- s_ready  out  1  loader accepts beat.
- rd_addr  in  ADDR_W  core pixel read address.
- rd_data  out  PIX_W  pixel at rd_addr, one-cycle latency.
- start  out  1  one-cycle pulse to core: image ready.
- core_done  in  1  core done level; loader uses its rising edge.
- img_valid  out  1  buffer holds a complete, accepted frame.
- frame_err  out  1  one-cycle pulse on malformed frame.
- frame_cnt  out  8  count of start pulses issued, wraps mod 256.

Behaviour:
- Reset (rst=0, asynchronous): state=S_LOAD, wr_ptr=0.
  - Outputs: s_ready=0, start=0, img_valid=0, frame_err=0, frame_cnt=0, rd_data=0.
  - Buffer contents are not cleared.
- s_ready is registered. It goes to 1 on the first clk edge after rst releases, if state allows.
- Beat accepted when s_valid && s_ready at a clk edge.
- States:
  - S_LOAD: s_ready=1. Accepted beat writes buf[wr_ptr]=s_data and increments wr_ptr.
    - First accepted beat of a frame clears img_valid.
    - s_last && wr_ptr==NPIX-1 -> S_START, wr_ptr=0.
    - s_last && wr_ptr<NPIX-1 (short frame) -> frame_err pulse, wr_ptr=0, stay S_LOAD.
    - !s_last && wr_ptr==NPIX-1 (overlong frame) -> frame_err pulse, wr_ptr=0, go to S_DROP.
  - S_DROP: s_ready=1. Beats are discarded; accepting a beat with s_last -> S_LOAD.
  - S_START: s_ready=0, start=1 for exactly this cycle, img_valid<=1, frame_cnt<=frame_cnt+1 -> S_BUSY.
  - S_BUSY: s_ready=0. Rising edge of core_done (registered delay-line detect) -> S_LOAD.
- Timing: start is high in the cycle after the edge that accepted the last beat.
- core_done edges outside S_BUSY are ignored. A core_done edge arriving in the cycle start is high is also ignored.
- Read port: rd_data <= buf[rd_addr] at every clk edge, in any state.
  - rd_addr >= NPIX returns 0.
  - A read and a write to the same address in one cycle return the old data.
- Reset mid-frame: partial frame is discarded and the next frame starts at pixel 0.

Optional Feature:
- Macro: LOADER_PINGPONG_EN.
- Defined:
  - Two buffer banks are used.
  - S_BUSY keeps s_ready=1 and loads the next frame into the inactive bank, with the same length checks as S_LOAD.
  - A completed frame moves to S_PEND: s_ready=0, wait for the core_done rising edge, then swap banks -> S_START.
  - A core_done edge with no pending frame -> S_LOAD, keeping any partial progress.
  - The read port always serves the active bank.
  - img_valid stays 1 across the swap.
- Undefined: single bank, behaviour exactly as above.

Test Plan:
1. Reset, stream 784 beats with s_data=i[7:0] and s_last on beat 784 -> start high exactly one cycle after the last beat.
   - frame_cnt=1, img_valid=1.
   - rd_addr=300 returns rd_data=0x2C next cycle; rd_addr=800 returns 0.
2. s_last on beat 100 -> frame_err single-cycle pulse, no start, img_valid=0. A following 784-beat frame then loads and starts normally.
3. 790 beats, s_last on beat 790 -> frame_err on beat 784, s_ready stays 1 through beat 790, no start. The next good frame starts with frame_cnt=1.
4. After start, hold s_valid=1 -> s_ready=0 until the core_done rise. s_ready=1 the cycle after the edge is registered; a core_done held high does not retrigger.
5. Assert rst at beat 400 -> all outputs go to reset values immediately, without waiting for a clock edge. A full frame after release gives start and frame_cnt=1.
6. (LOADER_PINGPONG_EN) Stream frame B while the core is busy on frame A -> no start until the core_done rise.
   - start then pulses, frame_cnt=2.
   - rd_data shows frame B pixels.
   - Frame A pixels remain readable until the swap.
